// File: rtl/seq_issue.sv
// Instruction-issue and writeback controller: latches one instruction, drives the ALU
// operand interface, waits (bounded) for the result and writes it back, or streams a register out.
module seq_issue #(
    parameter int alu_width      = 16,
    parameter int seq_op_width   = 2,
    parameter int seq_im_width   = 8,
    parameter int reg_addr_width = 4,
    parameter int max_wait       = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_instr_valid,
    output logic                      o_instr_ready,
    input  logic [seq_op_width-1:0]   i_instr_op,
    input  logic [reg_addr_width-1:0] i_instr_dst,
    input  logic [reg_addr_width-1:0] i_instr_src_a,
    input  logic [reg_addr_width-1:0] i_instr_src_b,
    input  logic [seq_im_width-1:0]   i_instr_const,
    output logic [alu_width-1:0]      o_alu_data_a,
    output logic [alu_width-1:0]      o_alu_data_b,
    output logic [seq_op_width-1:0]   o_alu_op,
    output logic [seq_im_width-1:0]   o_alu_const,
    output logic                      o_alu_valid,
    input  logic [alu_width-1:0]      i_alu_data,
    input  logic                      i_alu_valid,
    output logic [alu_width-1:0]      o_out_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic                      o_error,
    output logic                      o_busy,
    output logic [1:0]                o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the offering side holds its payload until the transfer.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    localparam logic [seq_op_width-1:0] OP_PUSH = seq_op_width'(0);
    localparam logic [seq_op_width-1:0] OP_SEND = seq_op_width'(3);
    localparam logic [3:0]              WAIT_LAST = 4'(max_wait - 1);
    localparam int                      NREG = 2 ** reg_addr_width;

    logic [1:0]                state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      issue_q;
    logic [reg_addr_width-1:0] dst_q;
    logic [alu_width-1:0]      res_q;
    logic [alu_width-1:0]      out_q;
    logic [alu_width-1:0]      alu_a_q, alu_b_q;
    logic [seq_op_width-1:0]   op_q;
    logic [seq_im_width-1:0]   const_q;
    logic [alu_width-1:0]      regs_q [NREG];

    logic accept;
    logic timeout;

    assign accept  = i_instr_valid && (state_q == ST_IDLE);
    assign timeout = (state_q == ST_EXEC) && !i_alu_valid && (cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            issue_q <= 1'b0;
            dst_q   <= '0;
            res_q   <= '0;
            out_q   <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            op_q    <= '0;
            const_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            issue_q <= accept && (i_instr_op != OP_SEND);
            if (accept) begin
                dst_q <= i_instr_dst;
                if (i_instr_op == OP_SEND) begin
                    out_q <= regs_q[i_instr_src_a];
                end else begin
                    // PUSH shifts the destination's own value, so it reads reg[dst] as operand A.
                    alu_a_q <= (i_instr_op == OP_PUSH) ? regs_q[i_instr_dst] : regs_q[i_instr_src_a];
                    alu_b_q <= (i_instr_op == OP_PUSH) ? '0 : regs_q[i_instr_src_b];
                    op_q    <= i_instr_op;
                    const_q <= i_instr_const;
                end
            end
            if ((state_q == ST_EXEC) && i_alu_valid) begin
                res_q <= i_alu_data;
            end
            if (state_q == ST_WB) begin
                regs_q[dst_q] <= res_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | timeout;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = (i_instr_op == OP_SEND) ? ST_SEND : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (i_alu_valid) begin
                    state_d = ST_WB;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: begin
                if (i_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        o_instr_ready = (state_q == ST_IDLE);
        o_busy        = (state_q != ST_IDLE);
        o_alu_valid   = (state_q == ST_EXEC) && issue_q;
        o_out_valid   = (state_q == ST_SEND);
        o_dbg_state   = state_q;
    end

    assign o_alu_data_a = alu_a_q;
    assign o_alu_data_b = alu_b_q;
    assign o_alu_op     = op_q;
    assign o_alu_const  = const_q;
    assign o_out_data   = out_q;
    assign o_error      = err_q;

endmodule

// File: tb/tb_seq_issue.sv
// Bench for seq_issue: directed instruction vectors, an ALU model with selectable latency,
// and queue-based monitors on the ALU issue strobe and the SEND output stream.
module tb_seq_issue;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;
    localparam logic [1:0] OP_SEND = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_instr_valid = 1'b0;
    logic        o_instr_ready;
    logic [1:0]  i_instr_op = '0;
    logic [3:0]  i_instr_dst = '0;
    logic [3:0]  i_instr_src_a = '0;
    logic [3:0]  i_instr_src_b = '0;
    logic [7:0]  i_instr_const = '0;
    logic [15:0] o_alu_data_a;
    logic [15:0] o_alu_data_b;
    logic [1:0]  o_alu_op;
    logic [7:0]  o_alu_const;
    logic        o_alu_valid;
    logic [15:0] i_alu_data;
    logic        i_alu_valid;
    logic [15:0] o_out_data;
    logic        o_out_valid;
    logic        i_out_ready = 1'b1;
    logic        o_error;
    logic        o_busy;
    logic [1:0]  o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // {care_b, a, b, op, const}
    logic [42:0] exp_alu_q[$];
    logic [15:0] exp_out_q[$];

    // ALU model controls
    int   alu_lat   = 0;
    logic alu_never = 1'b0;
    logic kick      = 1'b0;
    int   lat_cnt   = 0;
    logic prev_alu_v = 1'b0;

    seq_issue dut (
        .clk           (clk),
        .rst           (rst),
        .i_instr_valid (i_instr_valid),
        .o_instr_ready (o_instr_ready),
        .i_instr_op    (i_instr_op),
        .i_instr_dst   (i_instr_dst),
        .i_instr_src_a (i_instr_src_a),
        .i_instr_src_b (i_instr_src_b),
        .i_instr_const (i_instr_const),
        .o_alu_data_a  (o_alu_data_a),
        .o_alu_data_b  (o_alu_data_b),
        .o_alu_op      (o_alu_op),
        .o_alu_const   (o_alu_const),
        .o_alu_valid   (o_alu_valid),
        .i_alu_data    (i_alu_data),
        .i_alu_valid   (i_alu_valid),
        .o_out_data    (o_out_data),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_error       (o_error),
        .o_busy        (o_busy),
        .o_dbg_state   (o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ALU model
    function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [7:0] c);
        logic [31:0] t;
        case (op)
            OP_PUSH: begin
                t = {16'h0, a} << 8;
                return t[15:0] | {8'h00, c};
            end
            OP_ADD:  return a + b;
            OP_MULT: begin
                t = 32'(a) * 32'(b);
                return t[15:0];
            end
            default: return 16'h0;
        endcase
    endfunction

    assign i_alu_data  = alu_model(o_alu_op, o_alu_data_a, o_alu_data_b, o_alu_const);
    assign i_alu_valid = (!alu_never && alu_lat == 0 && o_alu_valid) || (lat_cnt == 1) || kick;

    always @(posedge clk) begin
        if (o_alu_valid && !alu_never && alu_lat > 0) lat_cnt <= alu_lat;
        else if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: ALU issue strobe
    always @(negedge clk) begin
        logic [42:0] e;
        if (o_alu_valid) begin
            check("alu_strobe_single_cycle", {31'h0, prev_alu_v}, 32'h0);
            if (exp_alu_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL alu_unexpected_issue: got strobe expected none");
            end else begin
                e = exp_alu_q.pop_front();
                check("alu_data_a", {16'h0, o_alu_data_a}, {16'h0, e[41:26]});
                if (e[42]) check("alu_data_b", {16'h0, o_alu_data_b}, {16'h0, e[25:10]});
                check("alu_op", {30'h0, o_alu_op}, {30'h0, e[9:8]});
                check("alu_const", {24'h0, o_alu_const}, {24'h0, e[7:0]});
            end
        end
        prev_alu_v = o_alu_valid;
    end

    // monitor: SEND stream
    always @(negedge clk) begin
        logic [15:0] e;
        if (o_out_valid && i_out_ready) begin
            if (exp_out_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_unexpected: got data %0h expected none", o_out_data);
            end else begin
                e = exp_out_q.pop_front();
                check("out_data", {16'h0, o_out_data}, {16'h0, e});
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] sa,
                         input logic [3:0] sb, input logic [7:0] c);
        int k;
        k = 0;
        while (!o_instr_ready && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!o_instr_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_wait_ready: got ready 0 expected 1 within 60 cycles");
        end
        i_instr_op    = op;
        i_instr_dst   = dst;
        i_instr_src_a = sa;
        i_instr_src_b = sb;
        i_instr_const = c;
        i_instr_valid = 1'b1;
        @(posedge clk);
        #1;
        i_instr_valid = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] sa,
                         input logic [3:0] sb, input logic [7:0] c, input logic [15:0] exp_a,
                         input logic [15:0] exp_b, input logic care_b, input int exp_lat);
        int   lat;
        logic stable_ok;
        exp_alu_q.push_back({care_b, exp_a, exp_b, op, c});
        issue(op, dst, sa, sb, c);
        lat = 1;
        stable_ok = 1'b1;
        while (!o_instr_ready && lat < 60) begin
            if (!o_busy || o_alu_data_a !== exp_a || (care_b && o_alu_data_b !== exp_b))
                stable_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("ready_latency", lat, exp_lat);
        check("busy_operands_stable", {31'h0, stable_ok}, 32'h1);
    endtask

    task automatic do_send(input logic [3:0] src, input logic [15:0] exp_d, input int hold);
        logic ok;
        exp_out_q.push_back(exp_d);
        i_out_ready = (hold == 0);
        issue(OP_SEND, 4'h0, src, 4'h0, 8'h00);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!o_out_valid || o_out_data !== exp_d || o_instr_ready) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        if (hold > 0) check("send_hold_stable", {31'h0, ok}, 32'h1);
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("send_return_idle", {31'h0, o_instr_ready}, 32'h1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_ready", {31'h0, o_instr_ready}, 32'h1);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_alu_valid", {31'h0, o_alu_valid}, 32'h0);
        check("rst_out_valid", {31'h0, o_out_valid}, 32'h0);
        check("rst_error", {31'h0, o_error}, 32'h0);
        check("rst_alu_operands", {o_alu_data_a, o_alu_data_b}, 32'h0);
        check("rst_alu_op_const", {22'h0, o_alu_op, o_alu_const}, 32'h0);

        // PUSH twice into reg1, then SEND
        do_op(OP_PUSH, 4'd1, 4'd0, 4'd0, 8'h12, 16'h0000, 16'h0000, 1'b0, 3);
        do_op(OP_PUSH, 4'd1, 4'd0, 4'd0, 8'h34, 16'h0012, 16'h0000, 1'b0, 3);
        do_send(4'd1, 16'h1234, 0);

        // ADD 3+5, then wrapping add 0xFFFF+2
        do_op(OP_PUSH, 4'd2, 4'd0, 4'd0, 8'h03, 16'h0000, 16'h0000, 1'b0, 3);
        do_op(OP_PUSH, 4'd3, 4'd0, 4'd0, 8'h05, 16'h0000, 16'h0000, 1'b0, 3);
        do_op(OP_ADD, 4'd4, 4'd2, 4'd3, 8'h00, 16'h0003, 16'h0005, 1'b1, 3);
        do_send(4'd4, 16'h0008, 0);
        do_op(OP_PUSH, 4'd6, 4'd0, 4'd0, 8'hFF, 16'h0000, 16'h0000, 1'b0, 3);
        do_op(OP_PUSH, 4'd6, 4'd0, 4'd0, 8'hFF, 16'h00FF, 16'h0000, 1'b0, 3);
        do_op(OP_PUSH, 4'd7, 4'd0, 4'd0, 8'h02, 16'h0000, 16'h0000, 1'b0, 3);
        do_op(OP_ADD, 4'd8, 4'd6, 4'd7, 8'h00, 16'hFFFF, 16'h0002, 1'b1, 3);
        do_send(4'd8, 16'h0001, 0);

        // fresh register file, MULT through a 4-cycle ALU
        pulse_reset();
        do_op(OP_PUSH, 4'd2, 4'd0, 4'd0, 8'h07, 16'h0000, 16'h0000, 1'b0, 3);
        do_op(OP_PUSH, 4'd3, 4'd0, 4'd0, 8'h06, 16'h0000, 16'h0000, 1'b0, 3);
        alu_lat = 4;
        do_op(OP_MULT, 4'd5, 4'd2, 4'd3, 8'h00, 16'h0007, 16'h0006, 1'b1, 7);
        alu_lat = 0;

        // SEND back-pressured for 5 cycles
        do_send(4'd5, 16'h002A, 5);

        // ALU never answers: timeout after 15 wait cycles
        alu_never = 1'b1;
        do_op(OP_MULT, 4'd5, 4'd2, 4'd3, 8'h00, 16'h0007, 16'h0006, 1'b1, 16);
        check("timeout_error_set", {31'h0, o_error}, 32'h1);
        kick = 1'b1;
        @(posedge clk);
        #1;
        kick = 1'b0;
        check("late_valid_ignored", {30'h0, o_busy, o_instr_ready}, 32'h1);
        do_send(4'd5, 16'h002A, 0);
        check("error_sticky", {31'h0, o_error}, 32'h1);

        // reset in EXEC after 2 wait cycles
        exp_alu_q.push_back({1'b1, 16'h0007, 16'h0006, OP_MULT, 8'h00});
        issue(OP_MULT, 4'd5, 4'd2, 4'd3, 8'h00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_busy", {31'h0, o_busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", {31'h0, o_instr_ready}, 32'h1);
        check("midrst_busy", {31'h0, o_busy}, 32'h0);
        check("midrst_error", {31'h0, o_error}, 32'h0);
        check("midrst_strobes", {30'h0, o_alu_valid, o_out_valid}, 32'h0);
        check("midrst_alu_a", {16'h0, o_alu_data_a}, 32'h0);
        rst = 1'b0;
        alu_never = 1'b0;
        do_send(4'd5, 16'h0000, 0);
        do_send(4'd3, 16'h0000, 0);

        repeat (3) @(posedge clk);
        #1;
        check("alu_queue_drained", exp_alu_q.size(), 32'h0);
        check("out_queue_drained", exp_out_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
